// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU result path and a FIFO-buffered
// load result path onto the register-file write port, and tracks which
// registers still have a load in flight so operand fetch can stall on them.
module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [5:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [5:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        issue_valid,
  input  logic [5:0]  issue_addr,
  input  logic [5:0]  query_addr1,
  input  logic [5:0]  query_addr2,
  output logic        busy1,
  output logic        busy2,
  output logic        rf_we,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err_bad_addr
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_e;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [31:0]        pending_q, pending_d;
  logic               rf_we_q, rf_we_d;
  logic [5:0]         rf_waddr_q, rf_waddr_d;
  logic [31:0]        rf_wdata_q, rf_wdata_d;
  src_e               rf_src_q, rf_src_d;
  logic               err_q, err_d;

  logic               fifo_nonempty;
  logic               fifo_full;
  logic               alu_grant;
  logic               fifo_pop;
  logic               fifo_push;
  logic               grant;
  entry_t             grant_entry;
  src_e               grant_src;

  // Handshakes and arbitration: ALU wins unless it has starved a non-empty FIFO.
  always_comb begin
    fifo_nonempty = (count_q != '0);
    fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
    load_ready    = !fifo_full;
    alu_ready     = !(fifo_nonempty && (starve_q == STV_W'(STARVE_LIMIT)));
    alu_grant     = alu_valid && alu_ready;
    fifo_pop      = !alu_grant && fifo_nonempty;
    fifo_push     = load_valid && !fifo_full;
    grant         = alu_grant || fifo_pop;
    if (alu_grant) begin
      grant_entry = '{addr: alu_addr, data: alu_data};
      grant_src   = SRC_ALU;
    end else begin
      grant_entry = mem_q[rd_ptr_q];
      grant_src   = SRC_LOAD;
    end
  end

  // Load FIFO: circular buffer; push and pop in one cycle leave the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = '{addr: load_addr, data: load_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  end

  // Starvation counter: counts ALU wins while loads wait, cleared otherwise.
  always_comb begin
    starve_d = starve_q;
    if (alu_grant) begin
      if (fifo_nonempty) begin
        if (starve_q != STV_W'(STARVE_LIMIT)) begin
          starve_d = starve_q + STV_W'(1);
        end
      end else begin
        starve_d = '0;
      end
    end else if (fifo_pop) begin
      starve_d = '0;
    end
  end

  // Output register: a granted entry with addr[5] set is consumed but not written.
  always_comb begin
    rf_we_d    = grant && !grant_entry.addr[5];
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_src_d   = rf_src_q;
    if (rf_we_d) begin
      rf_waddr_d = grant_entry.addr;
      rf_wdata_d = grant_entry.data;
      rf_src_d   = grant_src;
    end
    err_d = err_q || (grant && grant_entry.addr[5]);
  end

  // Pending-load scoreboard: cleared by a committing load write, set by issue (set wins).
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q && (rf_src_q == SRC_LOAD)) begin
      pending_d[rf_waddr_q[4:0]] = 1'b0;
    end
    if (issue_valid && !issue_addr[5]) begin
      pending_d[issue_addr[4:0]] = 1'b1;
    end
  end

  // Operand-fetch stall flags and registered write-port outputs.
  always_comb begin
    busy1        = pending_q[query_addr1[4:0]] && !query_addr1[5];
    busy2        = pending_q[query_addr2[4:0]] && !query_addr2[5];
    rf_we        = rf_we_q;
    rf_waddr     = rf_waddr_q;
    rf_wdata     = rf_wdata_q;
    err_bad_addr = err_q;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= SRC_ALU;
      err_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_src_q   <= rf_src_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based reference model with a scoreboard.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [5:0]  alu_addr;
  logic [31:0] alu_data;
  logic        load_valid, load_ready;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        issue_valid;
  logic [5:0]  issue_addr;
  logic [5:0]  query_addr1, query_addr2;
  logic        busy1, busy2;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_bad_addr;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .query_addr1(query_addr1), .query_addr2(query_addr2), .busy1(busy1), .busy2(busy2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_bad_addr(err_bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    bit          from_load;
  } wr_t;

  // Reference model state
  wr_t      m_fifo[$];
  wr_t      exp_q[$];
  int       m_starve;
  bit [31:0] m_pend;
  bit       m_out_we;
  bit       m_out_load;
  logic [4:0] m_out_idx;
  bit       m_err;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_alu_ready();
    return !(m_fifo.size() != 0 && m_starve == LIMIT);
  endfunction

  function automatic bit m_load_ready();
    return m_fifo.size() < DEPTH;
  endfunction

  function automatic bit m_busy(logic [5:0] q);
    return m_pend[q[4:0]] && !q[5];
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_starve   = 0;
    m_pend     = '0;
    m_out_we   = 0;
    m_out_load = 0;
    m_out_idx  = '0;
    m_err      = 0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs as driven.
  function automatic void model_clock();
    bit  a_ok, l_ok, have;
    wr_t g;
    g    = '{6'd0, 32'd0, 1'b0};
    a_ok = alu_valid && m_alu_ready();
    l_ok = load_valid && m_load_ready();
    if (m_out_we && m_out_load) m_pend[m_out_idx] = 1'b0;
    if (issue_valid && !issue_addr[5]) m_pend[issue_addr[4:0]] = 1'b1;
    have = 0;
    if (a_ok) begin
      g    = '{alu_addr, alu_data, 1'b0};
      have = 1;
      if (m_fifo.size() != 0) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
    end else if (m_fifo.size() != 0) begin
      g        = m_fifo.pop_front();
      have     = 1;
      m_starve = 0;
    end
    if (l_ok) m_fifo.push_back('{load_addr, load_data, 1'b1});
    m_out_we = have && !g.addr[5];
    if (have && g.addr[5]) m_err = 1;
    if (m_out_we) begin
      m_out_load = g.from_load;
      m_out_idx  = g.addr[4:0];
      exp_q.push_back(g);
    end
  endfunction

  // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
  task automatic step(input bit av, input logic [5:0] aa, input logic [31:0] ad,
                      input bit lv, input logic [5:0] la, input logic [31:0] ld,
                      input bit iv, input logic [5:0] ia,
                      input logic [5:0] q1, input logic [5:0] q2);
    #2;
    check("rf_we", rf_we, m_out_we);
    alu_valid = av;  alu_addr = aa;  alu_data = ad;
    load_valid = lv; load_addr = la; load_data = ld;
    issue_valid = iv; issue_addr = ia;
    query_addr1 = q1; query_addr2 = q2;
    #1;
    check("alu_ready", alu_ready, m_alu_ready());
    check("load_ready", load_ready, m_load_ready());
    check("busy1", busy1, m_busy(q1));
    check("busy2", busy2, m_busy(q2));
    check("err_bad_addr", err_bad_addr, m_err);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [5:0] q1);
    for (int i = 0; i < n; i++) step(0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 0, 6'd0, q1, q1);
  endtask

  task automatic do_reset(input int n);
    #2;
    reset = 1'b1;
    alu_valid = 0; load_valid = 0; issue_valid = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every presented write must match the next expected one.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", rf_we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rf_waddr", rf_waddr, e.addr);
          check("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    load_valid = 0; load_addr = '0; load_data = '0;
    issue_valid = 0; issue_addr = '0;
    query_addr1 = '0; query_addr2 = '0;
    model_reset();
    @(negedge clk);
    do_reset(2);
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_waddr", rf_waddr, 6'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    check("reset_err", err_bad_addr, 1'b0);
    idle(1, 6'd0);

    // ALU-only write
    step(1, 6'd5, 32'h1234, 0, 6'd0, 32'd0, 0, 6'd0, 6'd0, 6'd0);
    check("alu_we", rf_we, 1'b1);
    check("alu_waddr", rf_waddr, 6'd5);
    check("alu_wdata", rf_wdata, 32'h1234);
    idle(2, 6'd0);

    // Load ordering
    step(0, 6'd0, 32'd0, 1, 6'd7, 32'hA, 0, 6'd0, 6'd0, 6'd0);
    step(0, 6'd0, 32'd0, 1, 6'd8, 32'hB, 0, 6'd0, 6'd0, 6'd0);
    step(0, 6'd0, 32'd0, 1, 6'd9, 32'hC, 0, 6'd0, 6'd0, 6'd0);
    idle(4, 6'd0);

    // FIFO fills while the ALU hogs the port, then starvation forces a drain
    for (int i = 0; i < 4; i++)
      step(1, 6'(10 + i), 32'h100 + 32'(i), 1, 6'(16 + i), 32'h200 + 32'(i), 0, 6'd0, 6'd0, 6'd0);
    check("full_load_ready", load_ready, 1'b0);
    check("starved_alu_ready", alu_ready, 1'b0);
    step(1, 6'd14, 32'h104, 0, 6'd0, 32'd0, 0, 6'd0, 6'd0, 6'd0);
    check("after_drain_alu_ready", alu_ready, 1'b1);
    idle(6, 6'd0);

    // Scoreboard set, ALU write does not clear, load commit clears
    step(0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 1, 6'd12, 6'd12, 6'd0);
    check("busy_after_issue", busy1, 1'b1);
    step(1, 6'd12, 32'h99, 0, 6'd0, 32'd0, 0, 6'd0, 6'd12, 6'd12);
    idle(2, 6'd12);
    check("busy_after_alu_write", busy1, 1'b1);
    step(0, 6'd0, 32'd0, 1, 6'd12, 32'h55, 0, 6'd0, 6'd12, 6'd12);
    idle(1, 6'd12);
    check("load12_we", rf_we, 1'b1);
    check("busy_during_commit", busy1, 1'b1);
    idle(1, 6'd12);
    check("busy_after_commit", busy1, 1'b0);
    idle(1, 6'd12);

    // Set and clear of the same bit on one edge: set wins
    step(0, 6'd0, 32'd0, 1, 6'd12, 32'h66, 1, 6'd12, 6'd12, 6'd12);
    idle(1, 6'd12);
    check("load12b_we", rf_we, 1'b1);
    step(0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 1, 6'd12, 6'd12, 6'd12);
    check("set_wins", busy1, 1'b1);
    idle(2, 6'd12);

    // Bad address is consumed without a write and latches the error
    step(1, 6'h21, 32'hDEAD, 0, 6'd0, 32'd0, 0, 6'd0, 6'd0, 6'd0);
    check("bad_addr_no_we", rf_we, 1'b0);
    check("bad_addr_err", err_bad_addr, 1'b1);
    idle(3, 6'd0);
    check("bad_addr_err_sticky", err_bad_addr, 1'b1);

    // Mid-stream reset with two entries queued
    step(0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 1, 6'd20, 6'd20, 6'd0);
    step(1, 6'd3, 32'h31, 1, 6'd22, 32'h41, 0, 6'd0, 6'd20, 6'd0);
    step(1, 6'd4, 32'h32, 1, 6'd23, 32'h42, 0, 6'd0, 6'd20, 6'd0);
    do_reset(1);
    check("rst_err_cleared", err_bad_addr, 1'b0);
    step(0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 0, 6'd0, 6'd20, 6'd12);
    check("rst_busy_cleared", busy1, 1'b0);
    check("rst_no_write", rf_we, 1'b0);
    idle(4, 6'd20);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] aa, la, ia, q1, q2;
      aa = {($urandom_range(0, 19) == 0), 5'($urandom_range(0, 7))};
      la = {($urandom_range(0, 19) == 0), 5'($urandom_range(0, 7))};
      ia = {($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7))};
      q1 = {($urandom_range(0, 7) == 0), 5'($urandom_range(0, 7))};
      q2 = {($urandom_range(0, 7) == 0), 5'($urandom_range(0, 7))};
      step($urandom_range(0, 99) < 55, aa, $urandom,
           $urandom_range(0, 99) < 45, la, $urandom,
           $urandom_range(0, 99) < 30, ia, q1, q2);
    end
    idle(12, 6'd0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage feeding the single write port of the CPU register file (32 x 32-bit, 6-bit addresses, write on posedge when write enable is set).
- Merges two result sources into that port: the single-cycle ALU path and the multi-cycle load path. Load results are buffered in a small FIFO.
- Keeps a pending-load scoreboard so operand fetch can stall on registers whose load has not yet committed.

Parameters:
- FIFO_DEPTH, 4, load-result FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 3, consecutive ALU grants allowed while the FIFO is non-empty before the ALU is stalled.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  arbiter accepts the ALU result this cycle
- alu_addr  in  6  ALU destination register
- alu_data  in  32  ALU result
- load_valid  in  1  load result present
- load_ready  out  1  FIFO can accept
- load_addr  in  6  load destination register
- load_data  in  32  loaded word
- issue_valid  in  1  a load is issued this cycle
- issue_addr  in  6  destination of the issued load
- query_addr1  in  6  operand-fetch source 1
- query_addr2  in  6  operand-fetch source 2
- busy1  out  1  query_addr1 has an uncommitted load
- busy2  out  1  query_addr2 has an uncommitted load
- rf_we  out  1  register-file write enable
- rf_waddr  out  6  register-file write address
- rf_wdata  out  32  register-file write data
- err_bad_addr  out  1  sticky: a write with addr[5]=1 was dropped

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, starve counter 0, all pending bits 0, err_bad_addr=0. Reset overrides every in-flight operation.
- Handshakes:
  - A transfer occurs on a source when valid&ready are both high at the posedge.
  - load_ready = !full. It is not raised when a pop and a push coincide on a full FIFO.
  - alu_ready = !(fifo_nonempty && starve_cnt==STARVE_LIMIT).
- Arbitration, evaluated each cycle:
  - If alu_valid&alu_ready: grant ALU. starve_cnt increments (saturating) if the FIFO is non-empty, otherwise it clears.
  - Else if the FIFO is non-empty: pop the head and clear starve_cnt.
  - Else: no write.
- Output register:
  - A granted result appears on rf_we/rf_waddr/rf_wdata one cycle after the grant. The register file commits it at the following edge.
  - rf_we=0 when there is no grant. rf_waddr and rf_wdata hold their previous values when idle.
- Address check:
  - A granted entry with addr[5]=1 is consumed (handshake completes or the FIFO pops) but rf_we stays 0.
  - err_bad_addr is set and stays set until reset.
- Register 0 is an ordinary writable register; no special case.
- FIFO:
  - Circular buffer with read and write pointers and a count.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push on a non-full FIFO and a pop in the same cycle are both performed and the count is unchanged.
  - The FIFO preserves order.
- Scoreboard (pending[31:0]):
  - issue_valid with issue_addr[5]=0 sets pending[issue_addr].
  - The bit clears at the edge where rf_we=1 commits that address and the committed entry came from the load path. A 1-bit source tag is registered alongside rf_we.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - An ALU commit never clears a bit.
- busy outputs:
  - busy1 = pending[query_addr1[4:0]] & !query_addr1[5]; busy2 likewise. Both are combinational.
  - busy drops in the cycle after rf_we, so the register-file read in that cycle already returns the new value.

Test Plan:
- Reset, then ALU-only traffic: alu_valid=1 with addr=5, data=0x1234 -> the next cycle shows rf_we=1, rf_waddr=5, rf_wdata=0x1234. After reset the outputs are all 0.
- Load ordering: push loads (addr 7, 0xA), (8, 0xB), (9, 0xC) with the ALU idle -> three consecutive writes in order 7, 8, 9. load_ready stays 1.
- FIFO full: hold alu_valid=1 while pushing 4 loads -> load_ready=0 after the 4th push. alu_ready=0 after 3 ALU grants, then one load drains and alu_ready returns to 1.
- Scoreboard: issue 12 -> busy1=1 for query 12. Load (12, 0x55) writes; busy1 goes 0 the cycle after rf_we. An ALU write to 12 during pending leaves busy=1.
- Same-cycle set/clear: the load for 12 commits while issue_addr=12 -> pending[12] remains 1.
- Bad address: ALU write with addr=0x21 -> rf_we stays 0, err_bad_addr=1 until reset. Mid-stream reset with 2 FIFO entries -> FIFO empty, busy=0, and no further writes.
